// File: rtl/mem_bridge.sv
// mem_bridge: processor-to-async-SRAM bridge, IDLE/ACCESS/DONE FSM.
// In: req_rd/req_wr/addr/wdata, mem_rdata. Out: rdata/ack/busy, mem_* bus.
module mem_bridge #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [14:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ack,
  output logic        busy,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    unique case (state_q)
      IDLE: begin
        if (req_rd || req_wr) begin
          state_d = ACCESS;
          addr_d  = addr;
          wdat_d  = wdata;
          // Simultaneous rd+wr resolves to write.
          wr_d    = req_wr;
          cnt_d   = WS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (!wr_q) rdata_d = mem_rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes and ack decode the next state so they
  // come straight out of flops, aligned with state_q.
  always_comb begin
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    ack_d  = 1'b0;
    unique case (1'b1)
      (state_d == ACCESS): begin
        ce_n_d = 1'b0;
        oe_n_d = wr_d;
        we_n_d = !wr_d;
      end
      (state_d == DONE): begin
        ack_d = 1'b1;
      end
      default: begin
        ack_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      rdata_q <= 8'h00;
      ack_q   <= 1'b0;
      addr_q  <= 15'h0000;
      wdat_q  <= 8'h00;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdat_q;
  assign mem_ce_n  = ce_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed vector table plus corner sequences
// for mem_bridge with WAIT_STATES=2 (dut_a) and 0 (dut_b).
module tb_mem_bridge;

  logic        clk;
  logic        rst_n;
  logic        req_rd;
  logic        req_wr;
  logic [14:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  rdata_a, rdata_b;
  logic        ack_a, ack_b;
  logic        busy_a, busy_b;
  logic [14:0] maddr_a, maddr_b;
  logic [7:0]  mwd_a, mwd_b;
  logic        ce_a, ce_b;
  logic        oe_a, oe_b;
  logic        we_a, we_b;

  int checks;
  int failures;

  mem_bridge #(.WAIT_STATES(2)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata_a),
    .ack       (ack_a),
    .busy      (busy_a),
    .mem_addr  (maddr_a),
    .mem_wdata (mwd_a),
    .mem_rdata (mem_rdata),
    .mem_ce_n  (ce_a),
    .mem_oe_n  (oe_a),
    .mem_we_n  (we_a)
  );

  mem_bridge #(.WAIT_STATES(0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata_b),
    .ack       (ack_b),
    .busy      (busy_b),
    .mem_addr  (maddr_b),
    .mem_wdata (mwd_b),
    .mem_rdata (mem_rdata),
    .mem_ce_n  (ce_b),
    .mem_oe_n  (oe_b),
    .mem_we_n  (we_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [14:0] ad;
    logic [7:0]  wd;
    logic [7:0]  mrd;
    logic        busy;
    logic        ack;
    logic        ce;
    logic        oe;
    logic        we;
    logic [14:0] maddr;
    logic [7:0]  mwd;
    logic [7:0]  rdat;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(
    input logic rd, input logic wr,
    input logic [14:0] ad, input logic [7:0] wd,
    input logic [7:0] mrd, input logic b,
    input logic a, input logic ce,
    input logic oe, input logic we,
    input logic [14:0] ma, input logic [7:0] mw,
    input logic [7:0] rdt);
    vec_t r;
    r.rd = rd; r.wr = wr; r.ad = ad;
    r.wd = wd; r.mrd = mrd; r.busy = b;
    r.ack = a; r.ce = ce; r.oe = oe;
    r.we = we; r.maddr = ma; r.mwd = mw;
    r.rdat = rdt;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    // read 0x1234 -> 0xA5; request held into DONE/IDLE
    tbl[0]  = v(1,0,15'h1234,8'h11,8'hA5, 1,0,0,0,1,15'h1234,8'h11,8'h00);
    tbl[1]  = v(1,0,15'h1234,8'h11,8'hA5, 1,0,0,0,1,15'h1234,8'h11,8'h00);
    tbl[2]  = v(1,0,15'h1234,8'h11,8'hA5, 1,0,0,0,1,15'h1234,8'h11,8'h00);
    tbl[3]  = v(1,0,15'h1234,8'h11,8'hA5, 1,1,1,1,1,15'h1234,8'h11,8'hA5);
    tbl[4]  = v(1,0,15'h1234,8'h11,8'hA5, 0,0,1,1,1,15'h1234,8'h11,8'hA5);
    tbl[5]  = v(0,0,15'h1234,8'h11,8'hA5, 0,0,1,1,1,15'h1234,8'h11,8'hA5);
    // write 0x7FFF <- 0x3C; inputs disturbed mid-access
    tbl[6]  = v(0,1,15'h7FFF,8'h3C,8'h99, 1,0,0,1,0,15'h7FFF,8'h3C,8'hA5);
    tbl[7]  = v(0,1,15'h0000,8'h00,8'h99, 1,0,0,1,0,15'h7FFF,8'h3C,8'hA5);
    tbl[8]  = v(1,0,15'h0000,8'h00,8'h99, 1,0,0,1,0,15'h7FFF,8'h3C,8'hA5);
    tbl[9]  = v(0,1,15'h0000,8'h00,8'h99, 1,1,1,1,1,15'h7FFF,8'h3C,8'hA5);
    tbl[10] = v(0,0,15'h0000,8'h00,8'h99, 0,0,1,1,1,15'h7FFF,8'h3C,8'hA5);
    // rd+wr together -> write
    tbl[11] = v(1,1,15'h0100,8'h5A,8'h77, 1,0,0,1,0,15'h0100,8'h5A,8'hA5);
    tbl[12] = v(1,1,15'h0100,8'h5A,8'h77, 1,0,0,1,0,15'h0100,8'h5A,8'hA5);
    tbl[13] = v(1,1,15'h0100,8'h5A,8'h77, 1,0,0,1,0,15'h0100,8'h5A,8'hA5);
    tbl[14] = v(1,1,15'h0100,8'h5A,8'h77, 1,1,1,1,1,15'h0100,8'h5A,8'hA5);
    tbl[15] = v(0,0,15'h0100,8'h5A,8'h77, 0,0,1,1,1,15'h0100,8'h5A,8'hA5);
    // read 0x0010, addr moves to 0x0020 mid-access
    tbl[16] = v(1,0,15'h0010,8'h00,8'h42, 1,0,0,0,1,15'h0010,8'h00,8'hA5);
    tbl[17] = v(1,0,15'h0020,8'hFF,8'h42, 1,0,0,0,1,15'h0010,8'h00,8'hA5);
    tbl[18] = v(1,0,15'h0020,8'hFF,8'h42, 1,0,0,0,1,15'h0010,8'h00,8'hA5);
    tbl[19] = v(1,0,15'h0020,8'hFF,8'h42, 1,1,1,1,1,15'h0010,8'h00,8'h42);
    tbl[20] = v(0,0,15'h0020,8'hFF,8'h42, 0,0,1,1,1,15'h0010,8'h00,8'h42);

    req_rd = 0; req_wr = 0; addr = '0;
    wdata = '0; mem_rdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_strb", {29'd0, ce_a, oe_a, we_a}, 32'd7);
    chk("rst_maddr", 32'(maddr_a), 32'h0);
    chk("rst_mwd", 32'(mwd_a), 32'h0);
    chk("rst_rdata", 32'(rdata_a), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      req_rd = tbl[i].rd;
      req_wr = tbl[i].wr;
      addr = tbl[i].ad;
      wdata = tbl[i].wd;
      mem_rdata = tbl[i].mrd;
      tick();
      chk($sformatf("r%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
      chk($sformatf("r%0d_ack", i), 32'(ack_a), 32'(tbl[i].ack));
      chk($sformatf("r%0d_ce", i), 32'(ce_a), 32'(tbl[i].ce));
      chk($sformatf("r%0d_oe", i), 32'(oe_a), 32'(tbl[i].oe));
      chk($sformatf("r%0d_we", i), 32'(we_a), 32'(tbl[i].we));
      chk($sformatf("r%0d_maddr", i), 32'(maddr_a), 32'(tbl[i].maddr));
      chk($sformatf("r%0d_mwd", i), 32'(mwd_a), 32'(tbl[i].mwd));
      chk($sformatf("r%0d_rdata", i), 32'(rdata_a), 32'(tbl[i].rdat));
    end

    // reset pulse in 2nd ACCESS cycle of a read
    req_rd = 1; req_wr = 0;
    addr = 15'h0ABC; mem_rdata = 8'h66;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ab_strb", {29'd0, ce_a, oe_a, we_a}, 32'd7);
    chk("ab_busy", 32'(busy_a), 32'd0);
    chk("ab_ack", 32'(ack_a), 32'd0);
    chk("ab_rdata", 32'(rdata_a), 32'h0);
    chk("ab_maddr", 32'(maddr_a), 32'h0);
    tick();
    chk("ab_held_ack", 32'(ack_a), 32'd0);
    chk("ab_held_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_busy", 32'(busy_a), 32'd1);
    chk("ar_strb", {29'd0, ce_a, oe_a, we_a}, 32'd1);
    chk("ar_maddr", 32'(maddr_a), 32'h0ABC);
    n = 0;
    while (!ack_a && n < 10) begin
      tick();
      n++;
    end
    chk("ar_ack_lat", 32'(n), 32'd3);
    chk("ar_rdata", 32'(rdata_a), 32'h66);
    req_rd = 0;
    tick();

    // WAIT_STATES=0: held read, back-to-back
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req_rd = 1; addr = 15'h0001; mem_rdata = 8'hC3;
    tick();
    chk("b_acc_busy", 32'(busy_b), 32'd1);
    chk("b_acc_strb", {29'd0, ce_b, oe_b, we_b}, 32'd1);
    chk("b_acc_ack", 32'(ack_b), 32'd0);
    chk("b_acc_maddr", 32'(maddr_b), 32'h0001);
    tick();
    chk("b_done_ack", 32'(ack_b), 32'd1);
    chk("b_done_strb", {29'd0, ce_b, oe_b, we_b}, 32'd7);
    chk("b_done_rdata", 32'(rdata_b), 32'hC3);
    tick();
    chk("b_idle_ack", 32'(ack_b), 32'd0);
    chk("b_idle_busy", 32'(busy_b), 32'd0);
    n = 1;
    while (!ack_b && n < 10) begin
      tick();
      n++;
    end
    chk("b_ack_gap", 32'(n), 32'd3);
    req_rd = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
